// File: rtl/p_mul_seq.sv
// Sequencer between decode and a packed multiplier: latches one request, drives the
// multiplier handshake under a watchdog, and returns a tagged writeback.
module p_mul_seq (
    input  logic        clock,
    input  logic        resetn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_mul_l,
    input  logic        in_mul_h,
    input  logic        in_clmul,
    input  logic [4:0]  in_pw,
    input  logic [31:0] in_rs1,
    input  logic [31:0] in_rs2,
    input  logic [4:0]  in_rd,
    output logic        mul_valid,
    input  logic        mul_ready,
    output logic        mul_l,
    output logic        mul_h,
    output logic        clmul,
    output logic [4:0]  mul_pw,
    output logic [31:0] mul_crs1,
    output logic [31:0] mul_crs2,
    input  logic [31:0] mul_result,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_err,
    output logic        busy
);

    // state  | meaning
    // IDLE   | waiting for a request from decode
    // RUN    | request presented to the multiplier, watchdog counting
    // RESP   | writeback presented, waiting for wb_ready
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [5:0] WDOG_LAST = 6'd62;

    logic [1:0]  state;
    logic [5:0]  wdog;
    logic        req_l, req_h, req_c;
    logic [4:0]  req_pw;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic        pw_onehot, op_onehot, legal, accept;

    assign pw_onehot = (in_pw != 5'd0) && ((in_pw & (in_pw - 5'd1)) == 5'd0);
    // xor is 1 for one or three bits set; the and-term rejects three
    assign op_onehot = (in_mul_l ^ in_mul_h ^ in_clmul) && !(in_mul_l && in_mul_h && in_clmul);
    assign legal     = pw_onehot && op_onehot;

    assign in_ready  = (state == S_IDLE) && !flush;
    assign accept    = in_valid && in_ready;
    assign mul_valid = (state == S_RUN);
    assign wb_valid  = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    assign mul_l    = req_l;
    assign mul_h    = req_h;
    assign clmul    = req_c;
    assign mul_pw   = req_pw;
    assign mul_crs1 = req_rs1;
    assign mul_crs2 = req_rs2;
    assign wb_rd    = req_rd;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state   <= S_IDLE;
            wdog    <= '0;
            req_l   <= 1'b0;
            req_h   <= 1'b0;
            req_c   <= 1'b0;
            req_pw  <= '0;
            req_rs1 <= '0;
            req_rs2 <= '0;
            req_rd  <= '0;
            wb_data <= '0;
            wb_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_l   <= in_mul_l;
                        req_h   <= in_mul_h;
                        req_c   <= in_clmul;
                        req_pw  <= in_pw;
                        req_rs1 <= in_rs1;
                        req_rs2 <= in_rs2;
                        req_rd  <= in_rd;
                        wdog    <= '0;
                        if (legal) begin
                            state <= S_RUN;
                        end else begin
                            state   <= S_RESP;
                            wb_err  <= 1'b1;
                            wb_data <= '0;
                        end
                    end
                end
                S_RUN: begin
                    // a result arriving on the watchdog's last cycle still wins
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (mul_ready) begin
                        wb_data <= mul_result;
                        wb_err  <= 1'b0;
                        state   <= S_RESP;
                    end else if (wdog == WDOG_LAST) begin
                        wdog    <= wdog + 6'd1;
                        wb_data <= '0;
                        wb_err  <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        wdog <= wdog + 6'd1;
                    end
                end
                S_RESP: begin
                    if (flush || wb_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_p_mul_seq.sv
// Self-checking bench for p_mul_seq: a vector table of operations run against a
// latency-programmable multiplier stub, with a writeback scoreboard and corner sequences.
module tb_p_mul_seq;

    logic        clock = 1'b0;
    logic        resetn, flush, in_valid, in_ready;
    logic        in_mul_l, in_mul_h, in_clmul;
    logic [4:0]  in_pw, in_rd;
    logic [31:0] in_rs1, in_rs2;
    logic        mul_valid, mul_ready, mul_l, mul_h, clmul;
    logic [4:0]  mul_pw;
    logic [31:0] mul_crs1, mul_crs2, mul_result;
    logic        wb_valid, wb_ready, wb_err, busy;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    always #5 clock = ~clock;

    p_mul_seq dut (
        .clock(clock), .resetn(resetn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mul_l(in_mul_l), .in_mul_h(in_mul_h), .in_clmul(in_clmul),
        .in_pw(in_pw), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .mul_valid(mul_valid), .mul_ready(mul_ready),
        .mul_l(mul_l), .mul_h(mul_h), .clmul(clmul), .mul_pw(mul_pw),
        .mul_crs1(mul_crs1), .mul_crs2(mul_crs2), .mul_result(mul_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_rd(wb_rd), .wb_data(wb_data), .wb_err(wb_err), .busy(busy)
    );

    // multiplier stub: ready after stub_lat valid cycles; result only meaningful on handshake
    int   stub_lat = 0;
    bit   stub_never = 1'b0;
    bit   force_ready = 1'b0;
    int   stub_cnt = 0;
    assign mul_ready  = force_ready | (mul_valid && !stub_never && (stub_cnt == stub_lat));
    assign mul_result = (mul_valid && mul_ready) ? (mul_crs1 * mul_crs2) : 32'hDEAD_BEEF;
    always @(posedge clock) stub_cnt <= (mul_valid && !mul_ready) ? stub_cnt + 1 : 0;

    typedef struct {
        logic        l, h, c;
        logic [4:0]  pw;
        logic [31:0] rs1, rs2;
        logic [4:0]  rd;
        int          lat;
        bit          never;
        int          bp;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input vec_t v);
        in_valid = 1'b1;
        in_mul_l = v.l; in_mul_h = v.h; in_clmul = v.c;
        in_pw = v.pw; in_rs1 = v.rs1; in_rs2 = v.rs2; in_rd = v.rd;
    endtask

    // starts and ends on a negedge
    task automatic run_op(input vec_t v);
        int   k;
        int   mv_cnt;
        bit   got;
        exp_t e;
        exp_t s;
        stub_lat = v.lat;
        stub_never = v.never;
        drive_req(v);
        check("in_ready_idle", in_ready, 1);
        e.rd = v.rd;
        e.err = v.exp_err;
        e.data = v.exp_err ? 32'd0 : v.rs1 * v.rs2;
        sb.push_back(e);
        got = 1'b0;
        mv_cnt = 0;
        for (k = 1; k <= 200; k++) begin
            @(negedge clock);
            in_valid = 1'b0;
            if (mul_valid) mv_cnt++;
            if (mul_valid && mul_ready) begin
                check("req_op", {mul_l, mul_h, clmul}, {v.l, v.h, v.c});
                check("req_pw", mul_pw, v.pw);
                check("req_rs1", mul_crs1, v.rs1);
                check("req_rs2", mul_crs2, v.rs2);
            end
            if (wb_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            check("wb_timeout", 0, 1);
            return;
        end
        check("wb_latency", k, v.exp_lat);
        check("mul_valid_cycles", mv_cnt, v.exp_lat - 1);
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
            return;
        end
        s = sb.pop_front();
        for (int b = 0; b <= v.bp; b++) begin
            check("wb_rd", wb_rd, s.rd);
            check("wb_data", wb_data, s.data);
            check("wb_err", wb_err, s.err);
            if (b > 0) begin
                check("bp_wb_valid", wb_valid, 1);
                check("bp_in_ready", in_ready, 0);
                check("bp_busy", busy, 1);
            end
            if (b < v.bp) @(negedge clock);
        end
        wb_ready = 1'b1;
        @(negedge clock);
        wb_ready = 1'b0;
        check("idle_after_wb_busy", busy, 0);
        check("idle_after_wb_valid", wb_valid, 0);
    endtask

    // issue a legal op and return on the negedge of RUN cycle n
    task automatic start_run(input vec_t v, input int n);
        stub_lat = v.lat;
        stub_never = v.never;
        drive_req(v);
        for (int k = 1; k <= n; k++) begin
            @(negedge clock);
            in_valid = 1'b0;
        end
        check("run_mul_valid", mul_valid, 1);
    endtask

    vec_t vecs[10];
    vec_t v;

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        //        l     h     c     pw        rs1            rs2            rd     lat never bp exp_err exp_lat
        vecs[0] = '{1'b1, 1'b0, 1'b0, 5'b00001, 32'd3,         32'd5,         5'd7,  32, 1'b0, 0,  1'b0, 34};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 5'b00010, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3,  4,  1'b0, 10, 1'b0, 6};
        vecs[2] = '{1'b0, 1'b0, 1'b1, 5'b00100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 0,  1'b0, 2,  1'b0, 2};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 5'b00011, 32'd3,         32'd5,         5'd9,  0,  1'b0, 0,  1'b1, 1};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 5'b00001, 32'd7,         32'd9,         5'd1,  0,  1'b0, 1,  1'b1, 1};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 5'b00000, 32'd2,         32'd2,         5'd2,  0,  1'b0, 0,  1'b1, 1};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 5'b10000, 32'hA5A5_0001, 32'h0000_0003, 5'd4,  0,  1'b1, 0,  1'b1, 64};
        vecs[7] = '{1'b1, 1'b0, 1'b0, 5'b01000, 32'd1000,      32'd1000,      5'd5,  10, 1'b0, 0,  1'b0, 12};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 5'b00001, 32'h0001_0001, 32'h0000_0100, 5'd6,  62, 1'b0, 0,  1'b0, 64};
        vecs[9] = '{1'b1, 1'b1, 1'b1, 5'b00001, 32'd1,         32'd1,         5'd8,  0,  1'b0, 0,  1'b1, 1};

        resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
        in_mul_l = 1'b0; in_mul_h = 1'b0; in_clmul = 1'b0;
        in_pw = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        repeat (2) @(negedge clock);
        check("rst_in_ready", in_ready, 1);
        check("rst_mul_valid", mul_valid, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_wb", {wb_rd, wb_data, wb_err}, 0);
        check("rst_req", {mul_l, mul_h, clmul, mul_pw, mul_crs1, mul_crs2}, 0);
        resetn = 1'b1;
        @(negedge clock);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_busy", busy, 0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i]);
        end

        // flush at RUN cycle 5, then a pw=16 op completes normally
        start_run(vecs[0], 5);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_run_mul_valid", mul_valid, 0);
        check("flush_run_wb_valid", wb_valid, 0);
        check("flush_run_busy", busy, 0);
        begin
            int seen = 0;
            repeat (40) begin
                @(negedge clock);
                if (wb_valid) seen++;
            end
            check("flush_run_no_wb", seen, 0);
        end
        run_op(vecs[1]);

        // flush while writeback is pending, with and without a same-cycle handshake
        for (int j = 0; j < 2; j++) begin
            v = vecs[2];
            start_run(v, 1);
            @(negedge clock);
            check("resp_wb_valid", wb_valid, 1);
            flush = 1'b1;
            wb_ready = (j == 1);
            check("resp_flush_in_ready", in_ready, 0);
            @(negedge clock);
            flush = 1'b0;
            wb_ready = 1'b0;
            check("flush_resp_wb_valid", wb_valid, 0);
            check("flush_resp_busy", busy, 0);
        end

        // flush in IDLE blocks an accept
        v = vecs[0];
        drive_req(v);
        flush = 1'b1;
        check("flush_idle_in_ready", in_ready, 0);
        @(negedge clock);
        flush = 1'b0;
        in_valid = 1'b0;
        check("flush_idle_busy", busy, 0);
        check("flush_idle_mul_valid", mul_valid, 0);

        // reset mid-RUN with a late mul_ready
        v = vecs[7];
        v.never = 1'b1;
        start_run(v, 5);
        resetn = 1'b0;
        force_ready = 1'b1;
        @(negedge clock);
        check("rst_run_busy", busy, 0);
        check("rst_run_mul_valid", mul_valid, 0);
        check("rst_run_wb_valid", wb_valid, 0);
        check("rst_run_in_ready", in_ready, 1);
        check("rst_run_req", {mul_l, mul_h, clmul, mul_pw, mul_crs1, mul_crs2}, 0);
        check("rst_run_wb", {wb_rd, wb_data, wb_err}, 0);
        resetn = 1'b1;
        @(negedge clock);
        check("late_ready_busy", busy, 0);
        check("late_ready_wb_valid", wb_valid, 0);
        force_ready = 1'b0;
        run_op(vecs[0]);

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/p_mul_seq.md
P_MUL_SEQ -- requirements
Module: p_mul_seq

Interface
REQ-001 clock  in  1  clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 flush  in  1  pipeline abort; discards any in-flight operation.
REQ-004 in_valid / in_ready  in / out  1 / 1  issue handshake from decode.
REQ-005 in_mul_l, in_mul_h, in_clmul  in  1 each  operation select (low half, high half, carryless).
REQ-006 in_pw  in  5  one-hot pack width: bit0=32, bit1=16, bit2=8, bit3=4, bit4=2.
REQ-007 in_rs1, in_rs2  in  32 each  source operands.
REQ-008 in_rd  in  5  destination register tag.
REQ-009 mul_valid  out  1  request to the packed multiplier; held until mul_ready.
REQ-010 mul_ready  in  1  multiplier done; combinational, same cycle as valid result.
REQ-011 mul_l, mul_h, clmul, mul_pw, mul_crs1, mul_crs2  out  1/1/1/5/32/32  registered copies of the latched request.
REQ-012 mul_result  in  32  multiplier result; valid only when mul_valid && mul_ready.
REQ-013 wb_valid / wb_ready  out / in  1 / 1  writeback handshake.
REQ-014 wb_rd, wb_data, wb_err  out  5/32/1  writeback tag, data, error flag.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, RUN, RESP; one-hot or binary encoding is permitted.
REQ-017 IDLE: in_ready = !flush; all other handshake outputs 0.
REQ-018 Accept = in_valid && in_ready; latch all in_* fields into the request registers.
REQ-019 Legal request: in_pw one-hot AND exactly one of in_mul_l/in_mul_h/in_clmul set.
REQ-020 Legal accept -> RUN next cycle; illegal accept -> RESP next cycle with wb_err=1, wb_data=0; mul_valid never asserted.
REQ-021 RUN: mul_valid=1; request outputs stable for the whole of RUN.
REQ-022 RUN and mul_ready: capture mul_result into wb_data, wb_err=0 -> RESP; mul_valid=0 next cycle; the multiplier therefore sees valid dropped and clears.
REQ-023 Watchdog: 6-bit counter cleared on accept, incremented each RUN cycle without mul_ready; reaching 63 -> RESP with wb_err=1, wb_data=0.
REQ-024 mul_ready on the same cycle the watchdog reaches 63: the result wins, wb_err=0.
REQ-025 RESP: wb_valid=1; wb_rd/wb_data/wb_err held stable until wb_valid && wb_ready -> IDLE.
REQ-026 in_ready=0 in RUN and RESP; one operation is in flight at a time.
REQ-027 Latency, pw=32: accept at T, mul_valid from T+1, mul_ready at T+33, wb_valid at T+34.
REQ-028 flush in RUN or RESP -> IDLE next cycle; mul_valid=0 and wb_valid=0 from the next cycle; no writeback is produced.
REQ-029 flush in the same cycle as a wb handshake counts as delivered; next state is IDLE.
REQ-030 flush in IDLE with in_valid: no accept (in_ready=0).
REQ-031 mul_ready while not in RUN is ignored.

Reset
REQ-032 resetn=0 at a clock edge: state=IDLE; watchdog=0; request registers, wb_rd, wb_data, wb_err = 0.
REQ-033 Reset takes priority over flush and all handshakes, including reset asserted mid-RUN.
REQ-034 During reset and the first cycle after it: in_ready=1 (unless flush), mul_valid=0, wb_valid=0, busy=0.

Verification
REQ-035 Legal op, stub returns ready after 32 valid cycles: in_pw=00001, in_mul_l=1, rs1=3, rs2=5, rd=7, stub result 0x0000000F -> wb_valid at T+34, wb_data=0x0000000F, wb_rd=7, wb_err=0.
REQ-036 Illegal op: in_pw=00011 -> wb_valid at T+1, wb_err=1, wb_data=0; mul_valid stays 0 throughout.
REQ-037 Watchdog: stub never asserts ready -> mul_valid high for exactly 63 cycles, then wb_err=1; next accept proceeds normally.
REQ-038 Backpressure: wb_ready held low 10 cycles in RESP -> wb_* stable, in_ready=0, busy=1; IDLE one cycle after wb_ready rises.
REQ-039 Flush at RUN cycle 5 -> mul_valid=0 next cycle, no wb_valid; a following op with in_pw=00010 completes correctly.
REQ-040 resetn low mid-RUN -> all outputs at reset values next cycle; the late mul_ready is ignored.
